mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline. It consumes the EX/MEM register outputs, performs loads and stores against a data memory with a variable-latency ready handshake, and holds the upstream pipeline with `mem_stall` while an access is outstanding. It also contains the MEM/WB pipeline register that feeds writeback and the forwarding unit.

## Interface
- `ADDR_W`, 32, data-memory address width
- `DATA_W`, 32, data word width
- `RD_W`, 5, destination register index width

- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `aluresult`  in  DATA_W  effective address, or ALU result for non-memory ops
- `rd`  in  RD_W  destination register
- `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`  in  1 each  control bits from EX/MEM
- `mem_forwarded_rtdata`  in  DATA_W  store data
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  ADDR_W  access address
- `dmem_wdata`  out  DATA_W  store data
- `dmem_ready`  in  1  access complete this cycle
- `dmem_rdata`  in  DATA_W  load data, valid when `dmem_ready` = 1
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- `wb_aluresult`, `wb_memdata`  out  DATA_W  MEM/WB data
- `wb_rd`  out  RD_W  MEM/WB destination
- `wb_MemtoReg`, `wb_RegWrite`, `wb_valid`  out  1  MEM/WB control
- `misalign`  out  1  one-cycle flag for a misaligned access (only with `MEM_ALIGN_CHECK_EN`)

## Operation
- **Access detection:** an access exists when `MemRead | MemWrite`.
  - `MemWrite` has priority. If both are set, the access is a store.
- **FSM state IDLE**
  - With an access: drive `dmem_req` = 1 combinationally from the current inputs, with `dmem_we` = `MemWrite`, `dmem_addr` = `aluresult` and `dmem_wdata` = `mem_forwarded_rtdata`.
  - If `dmem_ready` = 1 in the same cycle, this is a zero-wait completion: `mem_stall` = 0 and MEM/WB loads the instruction at the edge.
  - If `dmem_ready` = 0: `mem_stall` = 1. Latch we/addr/wdata/rd/MemtoReg/RegWrite into holding registers and go to WAIT. MEM/WB loads a bubble.
  - Without an access: `dmem_req` = 0 and MEM/WB loads the instruction directly.
- **FSM state WAIT**
  - `dmem_req` = 1, driven from the holding registers.
  - `mem_stall` = ~`dmem_ready`.
  - On `dmem_ready`: MEM/WB loads the held instruction, `wb_memdata` takes `dmem_rdata`, and the FSM returns to IDLE. The upstream stages advance on the same edge, so the instruction is never issued twice.
- **Bubble:** `wb_RegWrite` = 0, `wb_valid` = 0, `wb_MemtoReg` = 0. Data fields are don't-care but are driven to 0.
- **Stores:** `wb_memdata` = 0. `wb_RegWrite` passes through from the control bits.
- **Register 0:** `rd` = 0 is passed through unchanged. Writeback suppresses it.

## Timing
- **Reset:** asynchronous on `rst_n` low. State = IDLE and every MEM/WB output = 0 (`wb_valid` = 0). Holding registers = 0. `misalign` = 0.
  - While `rst_n` is low, `dmem_req` and `mem_stall` are 0.
  - Reset during WAIT abandons the access. The memory must tolerate a dropped request.
- **Latency:**
  - Non-memory ops and zero-wait accesses: 1 cycle from EX/MEM to MEM/WB.
  - An access with N wait cycles: `mem_stall` is high for N cycles, and the result appears 1 cycle after `dmem_ready`.
- **Handshake:**
  - Once raised, `dmem_req` stays high with stable addr/we/wdata until the cycle `dmem_ready` = 1.
  - `dmem_ready` is ignored when `dmem_req` = 0.
- **Back-to-back accesses:** the next access may issue in the cycle after completion, with no idle cycle required.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:**
  - In IDLE, an access with `aluresult[1:0]` ≠ 0 does not assert `dmem_req` and does not stall.
  - MEM/WB loads a bubble.
  - `misalign` is registered high for exactly one cycle.
- **`MEM_ALIGN_CHECK_EN` undefined:**
  - No check is performed. The full address goes to `dmem_addr`.
  - `misalign` is tied to 0.

## Structure
- **Shared package `pipe_pkg`:**
  - FSM state enum `mem_state_t` (IDLE, WAIT)
  - width constants `ADDR_W`, `DATA_W`, `RD_W`
  - bubble constant for the MEM/WB control bundle
- **Sub-module:** `memwb_reg` holds the MEM/WB register, with a load-instruction/load-bubble select.
- **`mem_stage`:** the FSM, the holding registers and the request muxing.

## Test plan
- **Non-memory op:** ALU op with `aluresult` = 0x1234, `rd` = 7, `RegWrite` = 1 → next cycle `wb_aluresult` = 0x1234, `wb_rd` = 7, `wb_valid` = 1, `dmem_req` never asserted.
- **Zero-wait load:** load from addr 0x40 with `dmem_ready` = 1 in the same cycle and `dmem_rdata` = 0xDEADBEEF → `mem_stall` stays 0; next cycle `wb_memdata` = 0xDEADBEEF, `wb_MemtoReg` = 1.
- **Store with 3 wait cycles:** store 0xA5A5A5A5 to 0x80 → `mem_stall` high for 3 cycles with addr/wdata stable, exactly one completion, 3 bubbles in MEM/WB, and the store reaches MEM/WB with `wb_RegWrite` = 0.
- **Both bits set:** `MemRead` = `MemWrite` = 1 → `dmem_we` = 1.
- **Reset mid-WAIT:** drop `rst_n` during WAIT → `dmem_req`, `mem_stall` and all MEM/WB outputs go to 0 immediately; after release, state is IDLE.
- **Misaligned access, with `MEM_ALIGN_CHECK_EN`:** load from 0x42 → no `dmem_req`, `misalign` pulses for one cycle, bubble in MEM/WB.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline MEM stage: widths, FSM state and the MEM/WB control bundle.
package pipe_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic valid;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0, valid: 1'b0};

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register; every cycle it loads either the presented instruction or a bubble.
module memwb_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_instr,
    input  wb_ctrl_t          ctrl,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [DATA_W-1:0] memdata,
    input  logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] wb_aluresult,
    output logic [DATA_W-1:0] wb_memdata,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_MemtoReg,
    output logic              wb_RegWrite,
    output logic              wb_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_aluresult <= '0;
            wb_memdata   <= '0;
            wb_rd        <= '0;
            wb_MemtoReg  <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_valid     <= 1'b0;
        end else if (load_instr) begin
            wb_aluresult <= aluresult;
            wb_memdata   <= memdata;
            wb_rd        <= rd;
            wb_MemtoReg  <= ctrl.mem_to_reg;
            wb_RegWrite  <= ctrl.reg_write;
            wb_valid     <= ctrl.valid;
        end else begin
            // Bubble: data fields are cleared so downstream never sees stale values
            wb_aluresult <= '0;
            wb_memdata   <= '0;
            wb_rd        <= '0;
            wb_MemtoReg  <= WB_CTRL_BUBBLE.mem_to_reg;
            wb_RegWrite  <= WB_CTRL_BUBBLE.reg_write;
            wb_valid     <= WB_CTRL_BUBBLE.valid;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: request FSM with holding registers and stall generation, feeding memwb_reg.
// Optional alignment check is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [RD_W-1:0]   rd,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] mem_forwarded_rtdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] wb_aluresult,
    output logic [DATA_W-1:0] wb_memdata,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_MemtoReg,
    output logic              wb_RegWrite,
    output logic              wb_valid,
    output logic              misalign
);

    mem_state_t        state, next_state;
    logic              access, misaligned;
    logic              req_c, stall_c, load_instr, capture;
    logic              we_c;
    logic [DATA_W-1:0] addr_c, wdata_c, memdata_c;
    logic [RD_W-1:0]   rd_c;
    wb_ctrl_t          ctrl_c;

    logic              hold_we, hold_m2r, hold_rw;
    logic [DATA_W-1:0] hold_addr, hold_wdata;
    logic [RD_W-1:0]   hold_rd;

    assign access = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access && (aluresult[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= (state == IDLE) && misaligned;
    end
`else
    assign misaligned = 1'b0;
    assign misalign   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        load_instr = 1'b1;
        capture    = 1'b0;
        we_c       = MemWrite;
        addr_c     = aluresult;
        wdata_c    = mem_forwarded_rtdata;
        rd_c       = rd;
        ctrl_c     = '{mem_to_reg: MemtoReg, reg_write: RegWrite, valid: 1'b1};
        memdata_c  = '0;
        case (state)
            IDLE: begin
                if (access && misaligned) begin
                    load_instr = 1'b0;
                end else if (access) begin
                    req_c = 1'b1;
                    if (dmem_ready) begin
                        if (!MemWrite) memdata_c = dmem_rdata;
                    end else begin
                        stall_c    = 1'b1;
                        load_instr = 1'b0;
                        capture    = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // Request is replayed from the holding registers so it stays stable
                req_c   = 1'b1;
                we_c    = hold_we;
                addr_c  = hold_addr;
                wdata_c = hold_wdata;
                rd_c    = hold_rd;
                ctrl_c  = '{mem_to_reg: hold_m2r, reg_write: hold_rw, valid: 1'b1};
                if (dmem_ready) begin
                    if (!hold_we) memdata_c = dmem_rdata;
                    next_state = IDLE;
                end else begin
                    stall_c    = 1'b1;
                    load_instr = 1'b0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_we    <= 1'b0;
            hold_m2r   <= 1'b0;
            hold_rw    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_rd    <= '0;
        end else if (capture) begin
            hold_we    <= MemWrite;
            hold_m2r   <= MemtoReg;
            hold_rw    <= RegWrite;
            hold_addr  <= aluresult;
            hold_wdata <= mem_forwarded_rtdata;
            hold_rd    <= rd;
        end
    end

    // Reset forces the handshake and stall low even though the inputs may still request an access
    assign dmem_req   = req_c & rst_n;
    assign mem_stall  = stall_c & rst_n;
    assign dmem_we    = we_c;
    assign dmem_addr  = ADDR_W'(addr_c);
    assign dmem_wdata = wdata_c;

    memwb_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_memwb (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_instr   (load_instr),
        .ctrl         (ctrl_c),
        .aluresult    (addr_c),
        .memdata      (memdata_c),
        .rd           (rd_c),
        .wb_aluresult (wb_aluresult),
        .wb_memdata   (wb_memdata),
        .wb_rd        (wb_rd),
        .wb_MemtoReg  (wb_MemtoReg),
        .wb_RegWrite  (wb_RegWrite),
        .wb_valid     (wb_valid)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage; covers the MEM_ALIGN_CHECK_EN build and the default build.
module tb_mem_stage;

    typedef struct packed {
        logic        vld;
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] aluresult = '0;
    logic [4:0]  rd = '0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
    logic [31:0] mem_forwarded_rtdata = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall;
    logic [31:0] wb_aluresult, wb_memdata;
    logic [4:0]  wb_rd;
    logic        wb_MemtoReg, wb_RegWrite, wb_valid, misalign;

    wb_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;

    mem_stage dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .aluresult            (aluresult),
        .rd                   (rd),
        .MemRead              (MemRead),
        .MemWrite             (MemWrite),
        .MemtoReg             (MemtoReg),
        .RegWrite             (RegWrite),
        .mem_forwarded_rtdata (mem_forwarded_rtdata),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ready           (dmem_ready),
        .dmem_rdata           (dmem_rdata),
        .mem_stall            (mem_stall),
        .wb_aluresult         (wb_aluresult),
        .wb_memdata           (wb_memdata),
        .wb_rd                (wb_rd),
        .wb_MemtoReg          (wb_MemtoReg),
        .wb_RegWrite          (wb_RegWrite),
        .wb_valid             (wb_valid),
        .misalign             (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    function automatic wb_t mk(input logic v, input logic w, input logic m,
                               input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        mk = '{vld: v, rw: w, m2r: m, rd: r, alu: a, mem: d};
    endfunction

    function automatic wb_t wb_act();
        wb_act = {wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd, wb_aluresult, wb_memdata};
    endfunction

    task automatic set_in(input logic [31:0] a, input logic [4:0] r, input logic mr, input logic mw,
                          input logic m2r, input logic rw, input logic [31:0] wd,
                          input logic rdy, input logic [31:0] rdat);
        aluresult = a; rd = r; MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
        mem_forwarded_rtdata = wd; dmem_ready = rdy; dmem_rdata = rdat;
    endtask

    task automatic set_nop();
        set_in(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        wb_t e;
        set_in(32'h40, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        #2;
        compared++;
        if ({dmem_req, mem_stall, misalign} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got req/stall/misalign=%b, required 000", {dmem_req, mem_stall, misalign});
        end
        compared++;
        if (wb_act() !== wb_t'(0)) begin
            mismatched++;
            $display("FAIL reset_wb: got %h, required 0", wb_act());
        end
        @(negedge clk);
        set_nop();
        rst_n = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL reset_first_nop: got %h, required %h", wb_act(), e);
        end
    endtask

    task automatic test_nonmem();
        wb_t e;
        set_in(32'h1234, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        exp_q.push_back(mk(1, 1, 0, 7, 32'h1234, 0));
        #1;
        compared++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            mismatched++;
            $display("FAIL nonmem_req: got req/stall=%b, required 00", {dmem_req, mem_stall});
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL nonmem_wb: got %h, required %h", wb_act(), e);
        end
    endtask

    task automatic test_zero_wait_load();
        wb_t e;
        set_in(32'h40, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'hDEADBEEF);
        exp_q.push_back(mk(1, 1, 1, 3, 32'h40, 32'hDEADBEEF));
        #1;
        compared++;
        if ({dmem_req, dmem_we, mem_stall, dmem_addr} !== {3'b100, 32'h40}) begin
            mismatched++;
            $display("FAIL zw_load_bus: got req/we/stall=%b addr=%h, required 100 addr=00000040",
                     {dmem_req, dmem_we, mem_stall}, dmem_addr);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL zw_load_wb: got %h, required %h", wb_act(), e);
        end
    endtask

    task automatic test_store_wait3();
        wb_t e;
        int  stalls = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0)
                set_in(32'h80, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h0);
            else
                // Unrelated values on the inputs: the held request must not change
                set_in(32'hFFFF0000, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, (c == 3), 32'h12345678);
            if (c == 3) exp_q.push_back(mk(1, 0, 0, 9, 32'h80, 0));
            else        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            #1;
            if (mem_stall === 1'b1) stalls++;
            compared++;
            if ({dmem_req, dmem_we, mem_stall, dmem_addr, dmem_wdata} !==
                {2'b11, (c != 3), 32'h80, 32'hA5A5A5A5}) begin
                mismatched++;
                $display("FAIL store_bus c%0d: got req/we/stall=%b addr=%h wdata=%h, required 11%0d addr=00000080 wdata=a5a5a5a5",
                         c, {dmem_req, dmem_we, mem_stall}, dmem_addr, dmem_wdata, (c != 3));
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if (wb_act() !== e) begin
                mismatched++;
                $display("FAIL store_wb c%0d: got %h, required %h", c, wb_act(), e);
            end
        end
        compared++;
        if (stalls != 3) begin
            mismatched++;
            $display("FAIL store_stall_cycles: got %0d, required 3", stalls);
        end
        // A ready pulse with no request must be ignored
        set_in(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        #1;
        compared++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            mismatched++;
            $display("FAIL store_single_completion: got req/stall=%b, required 00", {dmem_req, mem_stall});
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL store_after_wb: got %h, required %h", wb_act(), e);
        end
    endtask

    task automatic test_both_bits();
        wb_t e;
        set_in(32'h100, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000BEEF, 1'b1, 32'h55555555);
        exp_q.push_back(mk(1, 0, 0, 2, 32'h100, 0));
        #1;
        compared++;
        if ({dmem_req, dmem_we, dmem_wdata} !== {2'b11, 32'h0000BEEF}) begin
            mismatched++;
            $display("FAIL both_bits_we: got req/we=%b wdata=%h, required 11 wdata=0000beef",
                     {dmem_req, dmem_we}, dmem_wdata);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL both_bits_wb: got %h, required %h", wb_act(), e);
        end
    endtask

    task automatic test_back_to_back();
        wb_t e;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin
                    set_in(32'h10, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
                    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
                end
                1: begin
                    dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
                    exp_q.push_back(mk(1, 1, 1, 11, 32'h10, 32'h11111111));
                end
                default: begin
                    set_in(32'h14, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h22222222);
                    exp_q.push_back(mk(1, 1, 1, 12, 32'h14, 32'h22222222));
                end
            endcase
            #1;
            compared++;
            if ({dmem_req, mem_stall, dmem_addr} !== {1'b1, (c == 0), (c == 2) ? 32'h14 : 32'h10}) begin
                mismatched++;
                $display("FAIL b2b_bus c%0d: got req/stall=%b addr=%h", c, {dmem_req, mem_stall}, dmem_addr);
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            compared++;
            if (wb_act() !== e) begin
                mismatched++;
                $display("FAIL b2b_wb c%0d: got %h, required %h", c, wb_act(), e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        wb_t e;
        set_in(32'h300, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL rmw_bubble: got %h, required %h", wb_act(), e);
        end
        #1;
        compared++;
        if ({dmem_req, mem_stall} !== 2'b11) begin
            mismatched++;
            $display("FAIL rmw_in_wait: got req/stall=%b, required 11", {dmem_req, mem_stall});
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({dmem_req, mem_stall, wb_act()} !== {2'b00, wb_t'(0)}) begin
            mismatched++;
            $display("FAIL rmw_reset: got req/stall=%b wb=%h, required 00 wb=0", {dmem_req, mem_stall}, wb_act());
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(32'h200, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 1'b0, 32'h0);
        #1;
        compared++;
        if ({dmem_req, dmem_we, mem_stall, dmem_addr, dmem_wdata} !== {3'b111, 32'h200, 32'h77}) begin
            mismatched++;
            $display("FAIL rmw_idle_after: got req/we/stall=%b addr=%h wdata=%h, required 111 addr=00000200 wdata=00000077",
                     {dmem_req, dmem_we, mem_stall}, dmem_addr, dmem_wdata);
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL rmw_store_bubble: got %h, required %h", wb_act(), e);
        end
        dmem_ready = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 6, 32'h200, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if (wb_act() !== e) begin
            mismatched++;
            $display("FAIL rmw_store_wb: got %h, required %h", wb_act(), e);
        end
        set_nop();
    endtask

    task automatic test_misalign();
        wb_t e;
        set_in(32'h42, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'hCAFE);
`ifdef MEM_ALIGN_CHECK_EN
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        #1;
        compared++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            mismatched++;
            $display("FAIL misalign_req: got req/stall=%b, required 00", {dmem_req, mem_stall});
        end
`else
        exp_q.push_back(mk(1, 1, 1, 5, 32'h42, 32'hCAFE));
        #1;
        compared++;
        if ({dmem_req, mem_stall, dmem_addr} !== {2'b10, 32'h42}) begin
            mismatched++;
            $display("FAIL unaligned_req: got req/stall=%b addr=%h, required 10 addr=00000042",
                     {dmem_req, mem_stall}, dmem_addr);
        end
`endif
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
`ifdef MEM_ALIGN_CHECK_EN
        if ({wb_act(), misalign} !== {e, 1'b1}) begin
`else
        if ({wb_act(), misalign} !== {e, 1'b0}) begin
`endif
            mismatched++;
            $display("FAIL misalign_wb: got wb=%h misalign=%b, required wb=%h", wb_act(), misalign, e);
        end
        set_nop();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        compared++;
        if ({wb_act(), misalign} !== {e, 1'b0}) begin
            mismatched++;
            $display("FAIL misalign_pulse_end: got wb=%h misalign=%b, required wb=%h misalign=0", wb_act(), misalign, e);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_zero_wait_load();
        test_store_wait3();
        test_both_bits();
        test_back_to_back();
        test_reset_mid_wait();
        test_misalign();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
